// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm sequencer: state encoding, time field
// widths and a helper that sizes the per-second timers.
package alarm_pkg;

   localparam int HR_W  = 5;
   localparam int MIN_W = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_t;

   // Holds values 0..n-1. A single-tick period still needs one bit.
   function automatic int tmr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the clock datapath/buttons and the alarm sequencer.
// master drives time, alarm and buttons; slave (the sequencer) drives status.
interface alarm_sequencer_if #(
   parameter int MAX_SNOOZES = 3
);
   import alarm_pkg::*;

   localparam int CNT_W = $clog2(MAX_SNOOZES + 1);

   // No valid/ready pair: sec_tick, snooze_btn and stop_btn are single-cycle
   // pulses sampled on the clock edge; time/alarm fields and alarm_en are levels.
   logic                 sec_tick;
   logic [HR_W-1:0]      time_hr;
   logic [MIN_W-1:0]     time_min;
   logic [HR_W-1:0]      alarm_hr;
   logic [MIN_W-1:0]     alarm_min;
   logic                 alarm_en;
   logic                 snooze_btn;
   logic                 stop_btn;
   logic                 ring;
   logic                 snoozing;
   logic [CNT_W-1:0]     snooze_cnt;
   logic                 missed;
   alarm_state_t         state;

   modport master (
      output sec_tick, time_hr, time_min, alarm_hr, alarm_min, alarm_en,
             snooze_btn, stop_btn,
      input  ring, snoozing, snooze_cnt, missed, state
   );

   modport slave (
      input  sec_tick, time_hr, time_min, alarm_hr, alarm_min, alarm_en,
             snooze_btn, stop_btn,
      output ring, snoozing, snooze_cnt, missed, state
   );

endinterface

// File: rtl/alarm_tick_timer.sv
// Loadable per-second counter: counts up or down on en until it reaches
// END_VAL, then holds; done flags the terminal value.
module alarm_tick_timer #(
   parameter int             W        = 4,
   parameter bit             UP       = 1'b1,
   parameter logic [W-1:0]   LOAD_VAL = '0,
   parameter logic [W-1:0]   END_VAL  = '0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic done
);

   logic [W-1:0] count;

   assign done = (count == END_VAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (en && !done) begin
         count <= UP ? count + 1'b1 : count - 1'b1;
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: detects the alarm minute, rings, snoozes and times out.
// Optional macro ALARM_SEQ_BEEP_EN gates ring with a 1 s on / 1 s off phase.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int TICKS_PER_MIN  = 60,
   parameter int RING_MINUTES   = 5,
   parameter int SNOOZE_MINUTES = 9,
   parameter int MAX_SNOOZES    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   alarm_sequencer_if.slave  bus
);

   localparam int CNT_W      = $clog2(MAX_SNOOZES + 1);
   localparam int RING_TICKS = RING_MINUTES * TICKS_PER_MIN;
   localparam int SNZ_TICKS  = SNOOZE_MINUTES * TICKS_PER_MIN;
   localparam int RING_W     = tmr_w(RING_TICKS);
   localparam int SNZ_W      = tmr_w(SNZ_TICKS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SNOOZES);

   alarm_state_t      state, next_state;
   logic              match, match_q, armed_q, trigger;
   logic              ring_load, snz_load, ring_done, snz_done;
   logic              inc_cnt, clr_cnt, set_missed, clr_missed;
   logic [CNT_W-1:0]  snooze_cnt_q;
   logic              missed_q;

   assign match = bus.alarm_en
                  && (bus.time_hr  == bus.alarm_hr)
                  && (bus.time_min == bus.alarm_min);

   // armed_q keeps the first edge after reset from counting: match_q must
   // hold a real sample before a rising edge of match means anything.
   assign trigger = match && !match_q && armed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         match_q      <= 1'b0;
         armed_q      <= 1'b0;
         snooze_cnt_q <= '0;
         missed_q     <= 1'b0;
      end else begin
         state   <= next_state;
         match_q <= match;
         armed_q <= 1'b1;
         if (clr_cnt)
            snooze_cnt_q <= '0;
         else if (inc_cnt)
            snooze_cnt_q <= snooze_cnt_q + 1'b1;
         if (clr_missed)
            missed_q <= 1'b0;
         else if (set_missed)
            missed_q <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      ring_load  = 1'b0;
      snz_load   = 1'b0;
      inc_cnt    = 1'b0;
      clr_cnt    = 1'b0;
      set_missed = 1'b0;
      clr_missed = bus.stop_btn;
      if (!bus.alarm_en) begin
         next_state = IDLE;
         clr_cnt    = 1'b1;
         clr_missed = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (trigger) begin
                  next_state = RINGING;
                  ring_load  = 1'b1;
                  clr_cnt    = 1'b1;
                  clr_missed = 1'b1;
               end
            end
            RINGING: begin
               if (bus.stop_btn) begin
                  next_state = IDLE;
                  clr_cnt    = 1'b1;
               end else if (bus.sec_tick && ring_done) begin
                  next_state = IDLE;
                  clr_cnt    = 1'b1;
                  set_missed = 1'b1;
               end else if (bus.snooze_btn && (snooze_cnt_q < CNT_MAX)) begin
                  next_state = SNOOZE;
                  inc_cnt    = 1'b1;
                  snz_load   = 1'b1;
               end
            end
            SNOOZE: begin
               if (bus.stop_btn) begin
                  next_state = IDLE;
                  clr_cnt    = 1'b1;
               end else if (bus.sec_tick && snz_done) begin
                  next_state = RINGING;
                  ring_load  = 1'b1;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   alarm_tick_timer #(
      .W        (RING_W),
      .UP       (1'b1),
      .LOAD_VAL ('0),
      .END_VAL  (RING_W'(RING_TICKS - 1))
   ) u_ring_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ring_load),
      .en    (bus.sec_tick && (state == RINGING)),
      .done  (ring_done)
   );

   alarm_tick_timer #(
      .W        (SNZ_W),
      .UP       (1'b0),
      .LOAD_VAL (SNZ_W'(SNZ_TICKS - 1)),
      .END_VAL  ('0)
   ) u_snz_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (snz_load),
      .en    (bus.sec_tick && (state == SNOOZE)),
      .done  (snz_done)
   );

   assign bus.state      = state;
   assign bus.snoozing   = (state == SNOOZE);
   assign bus.snooze_cnt = snooze_cnt_q;
   assign bus.missed     = missed_q;

`ifdef ALARM_SEQ_BEEP_EN
   logic phase_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         phase_q <= 1'b1;
      else if (ring_load)
         phase_q <= 1'b1;
      else if ((state == RINGING) && bus.sec_tick)
         phase_q <= ~phase_q;
   end

   assign bus.ring = (state == RINGING) && phase_q;
`else
   assign bus.ring = (state == RINGING);
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with a queue-based scoreboard; expected
// outputs are hand-computed for TICKS_PER_MIN=2, RING_MINUTES=2, SNOOZE_MINUTES=1, MAX_SNOOZES=2.
module tb_alarm_sequencer;

   localparam logic [1:0] ST_I = 2'd0;
   localparam logic [1:0] ST_R = 2'd1;
   localparam logic [1:0] ST_S = 2'd2;
`ifdef ALARM_SEQ_BEEP_EN
   localparam bit BEEP = 1'b1;
`else
   localparam bit BEEP = 1'b0;
`endif

   logic clk;
   logic rst_n;

   alarm_sequencer_if #(.MAX_SNOOZES(2)) bus ();

   alarm_sequencer #(
      .TICKS_PER_MIN  (2),
      .RING_MINUTES   (2),
      .SNOOZE_MINUTES (1),
      .MAX_SNOOZES    (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [6:0] exp_q[$];
   string      name_q[$];
   int         total = 0;
   int         bad   = 0;

   always @(negedge clk) begin
      logic [6:0] act, e;
      string      nm;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {bus.ring, bus.snoozing, bus.snooze_cnt, bus.missed, 2'(bus.state)};
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL %s: got {ring,snz,cnt,missed,state}=%b expected %b", nm, act, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic tick, input logic snz, input logic stp);
      bus.sec_tick   = tick;
      bus.snooze_btn = snz;
      bus.stop_btn   = stp;
      cyc();
      bus.sec_tick   = 1'b0;
      bus.snooze_btn = 1'b0;
      bus.stop_btn   = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
   endtask

   task automatic trigger();
      bus.time_min = 6'd31;
      cyc();
      bus.time_min = 6'd30;
      cyc();
   endtask

   // ph is the expected beep phase; only affects ring when the beep build is on.
   task automatic chk(input string nm, input logic [1:0] st, input logic [1:0] cnt,
                      input logic ms, input logic ph);
      logic r;
      r = (st == ST_R) && (!BEEP || ph);
      exp_q.push_back({r, (st == ST_S), cnt, ms, st});
      name_q.push_back(nm);
      for (int i = 0; i < 3 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         $display("FAIL %s: monitor did not consume expectation, got pending=%0d required 0",
                  nm, exp_q.size());
         $fatal(1, "scoreboard stalled");
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n          = 1'b0;
      bus.sec_tick   = 1'b0;
      bus.snooze_btn = 1'b0;
      bus.stop_btn   = 1'b0;
      bus.alarm_en   = 1'b1;
      bus.alarm_hr   = 5'd7;
      bus.alarm_min  = 6'd30;
      bus.time_hr    = 5'd7;
      bus.time_min   = 6'd29;
      repeat (2) cyc();
      chk("reset", ST_I, 2'd0, 1'b0, 1'b1);
      rst_n = 1'b1;
      cyc();

      // trigger, stop, no re-trigger within the alarm minute
      bus.time_min = 6'd30;
      cyc();
      chk("trigger", ST_R, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      chk("stop", ST_I, 2'd0, 1'b0, 1'b1);
      repeat (3) cyc();
      chk("no_retrigger", ST_I, 2'd0, 1'b0, 1'b1);

      // timeout after 4 ticks, missed cleared by stop and by next trigger
      trigger();
      chk("ring_timeout_start", ST_R, 2'd0, 1'b0, 1'b1);
      ticks(3);
      chk("ring_after_3_ticks", ST_R, 2'd0, 1'b0, 1'b0);
      ticks(1);
      chk("timeout", ST_I, 2'd0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      chk("missed_clr_stop", ST_I, 2'd0, 1'b0, 1'b1);
      trigger();
      ticks(4);
      chk("timeout2", ST_I, 2'd0, 1'b1, 1'b1);
      trigger();
      chk("missed_clr_trigger", ST_R, 2'd0, 1'b0, 1'b1);

      // snooze, ignored snooze_btn in SNOOZE, expiry, fresh timeout
      ticks(2);
      chk("pre_snooze", ST_R, 2'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      chk("snooze", ST_S, 2'd1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      chk("snooze_btn_in_snooze", ST_S, 2'd1, 1'b0, 1'b1);
      ticks(1);
      chk("snooze_1_tick", ST_S, 2'd1, 1'b0, 1'b1);
      ticks(1);
      chk("snooze_expiry", ST_R, 2'd1, 1'b0, 1'b1);
      ticks(3);
      chk("fresh_timeout", ST_R, 2'd1, 1'b0, 1'b0);
      ticks(1);
      chk("timeout_after_snooze", ST_I, 2'd0, 1'b1, 1'b1);

      // snooze limit
      trigger();
      drive(1'b0, 1'b1, 1'b0);
      ticks(2);
      chk("ring_after_snooze1", ST_R, 2'd1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      chk("snooze2", ST_S, 2'd2, 1'b0, 1'b1);
      ticks(2);
      chk("ring_after_snooze2", ST_R, 2'd2, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      chk("snooze_limit", ST_R, 2'd2, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
      chk("stop_clears_cnt", ST_I, 2'd0, 1'b0, 1'b1);

      // same-cycle priorities
      trigger();
      drive(1'b0, 1'b1, 1'b1);
      chk("stop_beats_snooze", ST_I, 2'd0, 1'b0, 1'b1);
      trigger();
      ticks(3);
      drive(1'b1, 1'b0, 1'b1);
      chk("stop_beats_timeout", ST_I, 2'd0, 1'b0, 1'b1);
      trigger();
      drive(1'b0, 1'b1, 1'b0);
      ticks(1);
      drive(1'b1, 1'b0, 1'b1);
      chk("expiry_with_stop", ST_I, 2'd0, 1'b0, 1'b1);

      // alarm_en dropped during SNOOZE
      trigger();
      drive(1'b0, 1'b1, 1'b0);
      chk("snooze_before_disable", ST_S, 2'd1, 1'b0, 1'b1);
      bus.alarm_en = 1'b0;
      cyc();
      chk("alarm_en_drop", ST_I, 2'd0, 1'b0, 1'b1);
      bus.time_min = 6'd31;
      bus.alarm_en = 1'b1;
      cyc();

      // asynchronous reset mid-ring, then a match already present at release
      trigger();
      chk("ring_before_reset", ST_R, 2'd0, 1'b0, 1'b1);
      cyc();
      rst_n = 1'b0;
      chk("async_reset", ST_I, 2'd0, 1'b0, 1'b1);
      cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("no_trigger_at_release", ST_I, 2'd0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
